// File: rtl/hazard_scoreboard_if.sv
// Pipeline-facing port bundle for the hazard/forwarding scoreboard.
// The master side is the decode stage; the slave side is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned LAT_W  = 2,
    parameter int unsigned SEL_W  = 2
);
    logic              advance;
    logic              flush;
    logic              id_valid;
    logic              id_we;
    logic [ADDR_W-1:0] id_waddr;
    logic [LAT_W-1:0]  id_lat;
    logic [ADDR_W-1:0] id_rs_addr;
    logic [ADDR_W-1:0] id_rt_addr;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_ll;
    logic              id_sc;
    logic              ll_invalidate;
    logic              stall;
    logic [SEL_W-1:0]  rs_fwd_sel;
    logic [SEL_W-1:0]  rt_fwd_sel;
    logic              atomic;
    logic              sc_fail;
    logic [DEPTH-1:0]  tag_valid;

    modport master (
        output advance, flush, id_valid, id_we, id_waddr, id_lat,
               id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_ll, id_sc, ll_invalidate,
        input  stall, rs_fwd_sel, rt_fwd_sel, atomic, sc_fail, tag_valid
    );

    modport slave (
        input  advance, flush, id_valid, id_we, id_waddr, id_lat,
               id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_ll, id_sc, ll_invalidate,
        output stall, rs_fwd_sel, rt_fwd_sel, atomic, sc_fail, tag_valid
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Destination-tag shift register (EX..WB) producing forward selects and decode stall,
// plus the LL/SC link bit.
module hazard_scoreboard #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned LAT_W  = 2,
    parameter int unsigned SEL_W  = 2
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LAT_W-1:0]  lat;
    } tag_t;

    tag_t              tags_q [DEPTH];
    tag_t              tags_d [DEPTH];
    logic              link_q, link_d;
    logic [ADDR_W-1:0] src  [2];
    logic              used [2];
    logic              haz  [2];
    logic [SEL_W-1:0]  sel  [2];
    logic              stall;
    logic              issue;
    logic [LAT_W-1:0]  cap_lat;
    logic [DEPTH-1:0]  tag_valid;

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        src[0]  = bus.id_rs_addr;
        src[1]  = bus.id_rt_addr;
        used[0] = bus.id_rs_used;
        used[1] = bus.id_rt_used;
        for (int s = 0; s < 2; s++) begin
            haz[s] = 1'b0;
            sel[s] = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (tags_q[i].valid && tags_q[i].we && (tags_q[i].addr == src[s]) &&
                    (src[s] != '0)) begin
                    sel[s] = SEL_W'(i + 1);
                    haz[s] = used[s] && (LAT_W'(i) < tags_q[i].lat);
                end
            end
        end
    end

    always_comb begin
        stall   = bus.id_valid & (haz[0] | haz[1]);
        issue   = bus.id_valid & ~stall & ~bus.flush;
        cap_lat = (32'(bus.id_lat) >= DEPTH) ? LAT_W'(DEPTH - 1) : bus.id_lat;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tags_d[i] = tags_q[i];
        end
        if (bus.advance) begin
            for (int i = 1; i < DEPTH; i++) begin
                tags_d[i] = tags_q[i-1];
            end
            tags_d[0] = '0;
            if (issue) begin
                tags_d[0].valid = 1'b1;
                tags_d[0].we    = bus.id_we;
                tags_d[0].addr  = bus.id_waddr;
                tags_d[0].lat   = cap_lat;
            end
        end
    end

    // A new link beats a same-cycle invalidate; invalidate acts even while frozen.
    always_comb begin
        link_d = link_q;
        if (bus.advance) begin
            if (issue && bus.id_ll) begin
                link_d = 1'b1;
            end else if (bus.ll_invalidate || (issue && bus.id_sc)) begin
                link_d = 1'b0;
            end
        end else if (bus.ll_invalidate) begin
            link_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tags_q[i] <= '0;
            end
            link_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tags_q[i] <= tags_d[i];
            end
            link_q <= link_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tag_valid[i] = tags_q[i].valid;
        end
    end

    assign bus.stall      = stall;
    assign bus.rs_fwd_sel = sel[0];
    assign bus.rt_fwd_sel = sel[1];
    assign bus.atomic     = link_q;
    assign bus.sc_fail    = bus.id_valid & bus.id_sc & (~link_q | bus.ll_invalidate);
    assign bus.tag_valid  = tag_valid;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.ADDR_W(5), .DEPTH(3), .LAT_W(2), .SEL_W(2)) bus ();

    hazard_scoreboard #(.ADDR_W(5), .DEPTH(3), .LAT_W(2), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic valid, input logic we, input logic [4:0] waddr,
                          input logic [1:0] lat, input logic [4:0] rs, input logic [4:0] rt,
                          input logic rs_used, input logic rt_used);
        bus.advance       = 1'b1;
        bus.flush         = 1'b0;
        bus.id_valid      = valid;
        bus.id_we         = we;
        bus.id_waddr      = waddr;
        bus.id_lat        = lat;
        bus.id_rs_addr    = rs;
        bus.id_rt_addr    = rt;
        bus.id_rs_used    = rs_used;
        bus.id_rt_used    = rt_used;
        bus.id_ll         = 1'b0;
        bus.id_sc         = 1'b0;
        bus.ll_invalidate = 1'b0;
        #1;
    endtask

    task automatic idle();
        set_id(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(bus.stall), 0);
        check("rst_tag_valid", 32'(bus.tag_valid), 0);
        check("rst_atomic", 32'(bus.atomic), 0);
        check("rst_rs_sel", 32'(bus.rs_fwd_sel), 0);

        // ALU producer r3 then dependents at distance 1 and 2
        set_id(1, 1, 5'd3, 2'd0, 5'd0, 5'd0, 0, 0);
        tick();
        set_id(1, 1, 5'd10, 2'd0, 5'd3, 5'd0, 1, 0);
        check("alu_stall", 32'(bus.stall), 0);
        check("alu_sel1", 32'(bus.rs_fwd_sel), 1);
        tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd3, 5'd0, 1, 0);
        check("alu_sel2", 32'(bus.rs_fwd_sel), 2);
        check("alu_tag_valid", 32'(bus.tag_valid), 3);
        drain();

        // Load-use: one bubble, then forward from stage 1
        set_id(1, 1, 5'd5, 2'd1, 5'd0, 5'd0, 0, 0);
        tick();
        set_id(1, 1, 5'd6, 2'd0, 5'd0, 5'd5, 0, 1);
        check("lu_stall", 32'(bus.stall), 1);
        tick();
        check("lu_stall_done", 32'(bus.stall), 0);
        check("lu_rt_sel", 32'(bus.rt_fwd_sel), 2);
        check("lu_bubble", 32'(bus.tag_valid), 2);
        drain();
        set_id(1, 1, 5'd5, 2'd1, 5'd0, 5'd0, 0, 0);
        tick();
        set_id(1, 1, 5'd6, 2'd0, 5'd0, 5'd5, 0, 0);
        check("lu_unused_stall", 32'(bus.stall), 0);
        drain();

        // MUL lat 2 then the clamped id_lat=3 form: both give two bubbles
        for (int k = 0; k < 2; k++) begin
            set_id(1, 1, 5'd7, (k == 0) ? 2'd2 : 2'd3, 5'd0, 5'd0, 0, 0);
            tick();
            set_id(1, 0, 5'd0, 2'd0, 5'd7, 5'd0, 1, 0);
            check("mul_stall1", 32'(bus.stall), 1);
            tick();
            check("mul_stall2", 32'(bus.stall), 1);
            tick();
            check("mul_stall_done", 32'(bus.stall), 0);
            check("mul_rs_sel", 32'(bus.rs_fwd_sel), 3);
            drain();
        end

        // r4 in stage 2 and stage 0: youngest wins
        set_id(1, 1, 5'd4, 2'd0, 5'd0, 5'd0, 0, 0);
        tick();
        idle();
        tick();
        set_id(1, 1, 5'd4, 2'd0, 5'd0, 5'd0, 0, 0);
        tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd4, 5'd4, 1, 0);
        check("prio_tag_valid", 32'(bus.tag_valid), 5);
        check("prio_rs_sel", 32'(bus.rs_fwd_sel), 1);
        check("prio_rt_sel", 32'(bus.rt_fwd_sel), 1);
        drain();

        // r0 never hits
        set_id(1, 1, 5'd0, 2'd1, 5'd0, 5'd0, 0, 0);
        tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd0, 5'd0, 1, 1);
        check("r0_sel", 32'(bus.rs_fwd_sel), 0);
        check("r0_stall", 32'(bus.stall), 0);
        drain();

        // non-writing producer never hits
        set_id(1, 0, 5'd9, 2'd1, 5'd0, 5'd0, 0, 0);
        tick();
        set_id(1, 0, 5'd0, 2'd0, 5'd0, 5'd9, 0, 1);
        check("nowe_sel", 32'(bus.rt_fwd_sel), 0);
        check("nowe_stall", 32'(bus.stall), 0);
        drain();

        // freeze for 3 cycles during a load-use stall
        set_id(1, 1, 5'd5, 2'd1, 5'd0, 5'd0, 0, 0);
        tick();
        set_id(1, 1, 5'd6, 2'd0, 5'd0, 5'd5, 0, 1);
        bus.advance = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frz_stall", 32'(bus.stall), 1);
            check("frz_tag_valid", 32'(bus.tag_valid), 1);
            check("frz_rt_sel", 32'(bus.rt_fwd_sel), 1);
        end
        bus.advance = 1'b1;
        tick();
        check("frz_release_stall", 32'(bus.stall), 0);
        check("frz_release_sel", 32'(bus.rt_fwd_sel), 2);
        drain();

        // reset mid-stall with the link set
        set_id(1, 1, 5'd8, 2'd1, 5'd0, 5'd0, 0, 0);
        bus.id_ll = 1'b1;
        tick();
        check("rstm_atomic_set", 32'(bus.atomic), 1);
        set_id(1, 1, 5'd5, 2'd1, 5'd0, 5'd0, 0, 0);
        tick();
        set_id(1, 1, 5'd6, 2'd0, 5'd0, 5'd5, 0, 1);
        check("rstm_stall", 32'(bus.stall), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstm_stall_clr", 32'(bus.stall), 0);
        check("rstm_tag_valid", 32'(bus.tag_valid), 0);
        check("rstm_atomic", 32'(bus.atomic), 0);
        drain();

        // LL then SC succeeds; second SC fails
        idle();
        bus.id_valid = 1'b1;
        bus.id_ll    = 1'b1;
        tick();
        check("llsc_atomic", 32'(bus.atomic), 1);
        idle();
        bus.id_valid = 1'b1;
        bus.id_sc    = 1'b1;
        #1;
        check("llsc_sc_ok", 32'(bus.sc_fail), 0);
        tick();
        check("llsc_atomic_clr", 32'(bus.atomic), 0);
        check("llsc_sc2_fail", 32'(bus.sc_fail), 1);
        tick();

        // LL, invalidate, SC fails
        idle();
        bus.id_valid = 1'b1;
        bus.id_ll    = 1'b1;
        tick();
        idle();
        bus.ll_invalidate = 1'b1;
        tick();
        check("inv_atomic", 32'(bus.atomic), 0);
        idle();
        bus.id_valid = 1'b1;
        bus.id_sc    = 1'b1;
        #1;
        check("inv_sc_fail", 32'(bus.sc_fail), 1);
        tick();

        // invalidate coinciding with LL issue: set wins
        idle();
        bus.id_valid      = 1'b1;
        bus.id_ll         = 1'b1;
        bus.ll_invalidate = 1'b1;
        tick();
        check("ll_inv_same", 32'(bus.atomic), 1);

        // invalidate while frozen still clears
        idle();
        bus.advance       = 1'b0;
        bus.ll_invalidate = 1'b1;
        tick();
        check("frz_inv_atomic", 32'(bus.atomic), 0);

        // flushed LL does not link
        idle();
        bus.id_valid = 1'b1;
        bus.id_ll    = 1'b1;
        bus.flush    = 1'b1;
        tick();
        check("flush_ll_atomic", 32'(bus.atomic), 0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
